// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-side PC sequencer.
// Holds the FSM state encoding, PC step and alignment check.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } pcs_state_e;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned PC_STEP    = 4;

    function automatic logic is_aligned(input logic [1:0] pc_lo);
        return pc_lo == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a fetched instruction and its PC.
// Flush wins over load; contents stay frozen until the next load.
module fetch_buf #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] pc_o
);

    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC controller: one outstanding imem request, one buffered
// instruction, redirects from execute with stale-response kill.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(64'h8000_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redir_valid_i,
    input  logic [DATA_WIDTH-1:0] redir_pc_i,
    output logic                  imem_req_valid_o,
    output logic [DATA_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] inst_pc_o,
    input  logic                  inst_ready_i,
    output logic                  misalign_o
);

    pcs_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  kill_q, kill_d;
    logic                  halt_pend_q, halt_pend_d;
    logic                  mis_q, mis_d;
    logic                  rst_seen_q, rst_seen_d;

    logic aligned, redir_ok, redir_bad, hs, rsp;
    logic buf_load, buf_flush;

    assign aligned   = is_aligned(redir_pc_i[1:0]);
    assign redir_ok  = redir_valid_i & aligned;
    assign redir_bad = redir_valid_i & ~aligned;
    assign hs        = (state_q == REQ) & imem_req_ready_i;
    // Responses to requests issued before reset never count.
    assign rsp       = imem_rsp_valid_i & ~rst_seen_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        kill_d      = kill_q;
        halt_pend_d = halt_pend_q;
        mis_d       = redir_bad;
        rst_seen_d  = rst_seen_q & ~(hs | imem_rsp_valid_i);
        buf_load    = 1'b0;
        buf_flush   = redir_valid_i;
        unique case (state_q)
            REQ: begin
                if (redir_valid_i) begin
                    kill_d      = 1'b1;
                    halt_pend_d = redir_bad;
                    if (redir_ok) pend_d = redir_pc_i;
                end
                if (hs) state_d = WAIT;
            end
            WAIT: begin
                if (rsp && (redir_valid_i || kill_q)) begin
                    kill_d      = 1'b0;
                    halt_pend_d = 1'b0;
                    if (redir_ok) begin
                        pc_d    = redir_pc_i;
                        state_d = REQ;
                    end else if (redir_bad || halt_pend_q) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pend_q;
                        state_d = REQ;
                    end
                end else if (rsp) begin
                    buf_load = 1'b1;
                    pc_d     = pc_q + DATA_WIDTH'(PC_STEP);
                    state_d  = HOLD;
                end else if (redir_valid_i) begin
                    kill_d      = 1'b1;
                    halt_pend_d = redir_bad;
                    if (redir_ok) pend_d = redir_pc_i;
                end
            end
            IDLE, HOLD, HALT: begin
                if (redir_ok) begin
                    pc_d        = redir_pc_i;
                    halt_pend_d = 1'b0;
                    state_d     = REQ;
                end else if (redir_bad) begin
                    state_d = HALT;
                end else if (state_q == IDLE) begin
                    state_d = REQ;
                end else if (state_q == HOLD && inst_ready_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            kill_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            mis_q       <= 1'b0;
            rst_seen_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            kill_q      <= kill_d;
            halt_pend_q <= halt_pend_d;
            mis_q       <= mis_d;
            rst_seen_q  <= rst_seen_d;
        end
    end

    fetch_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .INST_WIDTH(INST_WIDTH)
    ) u_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (buf_load),
        .inst_i (imem_rsp_data_i),
        .pc_i   (pc_q),
        .flush_i(buf_flush),
        .ready_i(inst_ready_i),
        .valid_o(inst_valid_o),
        .inst_o (inst_o),
        .pc_o   (inst_pc_o)
    );

    assign imem_req_valid_o = (state_q == REQ);
    assign imem_req_addr_o  = pc_q;
    assign misalign_o       = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed per-cycle vector bench for pc_sequencer.
// Each row: inputs for one cycle plus the outputs expected in it.
module tb_pc_sequencer;

    localparam logic [63:0] B    = 64'h8000_0000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
    localparam logic [31:0] A0   = 32'hA000_0000;
    localparam logic [31:0] A1   = 32'hA000_0001;
    localparam logic [31:0] A2   = 32'hA000_0002;
    localparam logic [31:0] A3   = 32'hA000_0003;
    localparam logic [31:0] A4   = 32'hA000_0004;
    localparam logic [31:0] A5   = 32'hA000_0005;
    localparam logic [31:0] A6   = 32'hA000_0006;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        misalign;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        ri;
        logic [63:0] rp;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        qv;
        logic [63:0] qa;
        logic        iv;
        logic [31:0] ii;
        logic [63:0] ip;
        logic        mis;
    } vec_t;

    vec_t vq[$];

    pc_sequencer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .redir_valid_i   (redir_valid),
        .redir_pc_i      (redir_pc),
        .imem_req_valid_o(req_valid),
        .imem_req_addr_o (req_addr),
        .imem_req_ready_i(req_ready),
        .imem_rsp_valid_i(rsp_valid),
        .imem_rsp_data_i (rsp_data),
        .inst_valid_o    (inst_valid),
        .inst_o          (inst),
        .inst_pc_o       (inst_pc),
        .inst_ready_i    (inst_ready),
        .misalign_o      (misalign)
    );

    always #5 clk = ~clk;

    task automatic add(
        input logic ri, input logic [63:0] rp, input logic rdy,
        input logic rv, input logic [31:0] rd, input logic ir,
        input logic qv, input logic [63:0] qa, input logic iv,
        input logic [31:0] ii, input logic [63:0] ip, input logic mis
    );
        vec_t v;
        v.ri = ri; v.rp = rp; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.ir = ir; v.qv = qv; v.qa = qa; v.iv = iv; v.ii = ii;
        v.ip = ip; v.mis = mis;
        vq.push_back(v);
    endtask

    task automatic chk(
        input string nm, input logic qv, input logic [63:0] qa,
        input logic iv, input logic [31:0] ii, input logic [63:0] ip,
        input logic mis
    );
        total++;
        if ({req_valid, req_addr, inst_valid, inst, inst_pc, misalign}
            !== {qv, qa, iv, ii, ip, mis}) begin
            $display("FAIL %s: got qv=%0b addr=%h iv=%0b inst=%h pc=%h mis=%0b want qv=%0b addr=%h iv=%0b inst=%h pc=%h mis=%0b",
                     nm, req_valid, req_addr, inst_valid, inst, inst_pc,
                     misalign, qv, qa, iv, ii, ip, mis);
        end else begin
            passed++;
        end
    endtask

    initial begin
        rst = 1'b1; redir_valid = 1'b0; redir_pc = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0;

        //   ri rp        rdy rv rd   ir  qv qa        iv ii  ip        mis
        // in-order fetch, 1-cycle latency
        add(0, 0,        1, 0, 0,  1,  1, B,        0, 0,  0,        0);
        add(0, 0,        0, 1, A0, 1,  0, B,        0, 0,  0,        0);
        add(0, 0,        1, 0, 0,  1,  0, B+4,      1, A0, B,        0);
        add(0, 0,        1, 0, 0,  1,  1, B+4,      0, A0, B,        0);
        add(0, 0,        0, 1, A1, 0,  0, B+4,      0, A0, B,        0);
        add(0, 0,        0, 0, 0,  1,  0, B+8,      1, A1, B+4,      0);
        add(0, 0,        1, 0, 0,  0,  1, B+8,      0, A1, B+4,      0);
        add(0, 0,        0, 1, A2, 0,  0, B+8,      0, A1, B+4,      0);
        // decode stall in HOLD
        for (int k = 0; k < 5; k++)
            add(0, 0,    1, 0, 0,  0,  0, B+'hC,    1, A2, B+8,      0);
        add(0, 0,        0, 0, 0,  1,  0, B+'hC,    1, A2, B+8,      0);
        add(0, 0,        1, 0, 0,  0,  1, B+'hC,    0, A2, B+8,      0);
        // redirect in WAIT, latency 3
        add(1, B+'h100,  0, 0, 0,  0,  0, B+'hC,    0, A2, B+8,      0);
        add(0, 0,        0, 0, 0,  0,  0, B+'hC,    0, A2, B+8,      0);
        add(0, 0,        0, 1, DEAD, 0, 0, B+'hC,   0, A2, B+8,      0);
        add(0, 0,        1, 0, 0,  0,  1, B+'h100,  0, A2, B+8,      0);
        add(0, 0,        0, 1, A3, 0,  0, B+'h100,  0, A2, B+8,      0);
        add(0, 0,        0, 0, 0,  1,  0, B+'h104,  1, A3, B+'h100,  0);
        // redirect in REQ while memory not ready
        add(1, B+'h100,  0, 0, 0,  0,  1, B+'h104,  0, A3, B+'h100,  0);
        add(0, 0,        0, 0, 0,  0,  1, B+'h104,  0, A3, B+'h100,  0);
        add(0, 0,        1, 0, 0,  0,  1, B+'h104,  0, A3, B+'h100,  0);
        add(0, 0,        0, 1, DEAD, 0, 0, B+'h104, 0, A3, B+'h100,  0);
        add(0, 0,        1, 0, 0,  0,  1, B+'h100,  0, A3, B+'h100,  0);
        add(0, 0,        0, 1, A4, 0,  0, B+'h100,  0, A3, B+'h100,  0);
        // misaligned redirect from HOLD, then resume
        add(1, B+'h102,  0, 0, 0,  1,  0, B+'h104,  1, A4, B+'h100,  0);
        add(0, 0,        1, 0, 0,  0,  0, B+'h104,  0, A4, B+'h100,  1);
        add(0, 0,        1, 0, 0,  0,  0, B+'h104,  0, A4, B+'h100,  0);
        add(1, B+'h200,  0, 0, 0,  0,  0, B+'h104,  0, A4, B+'h100,  0);
        add(0, 0,        1, 0, 0,  0,  1, B+'h200,  0, A4, B+'h100,  0);
        // response and redirect in the same WAIT cycle
        add(1, B+'h300,  0, 1, DEAD, 0, 0, B+'h200, 0, A4, B+'h100,  0);
        add(0, 0,        1, 0, 0,  0,  1, B+'h300,  0, A4, B+'h100,  0);
        add(0, 0,        0, 1, A5, 0,  0, B+'h300,  0, A4, B+'h100,  0);
        add(0, 0,        0, 0, 0,  1,  0, B+'h304,  1, A5, B+'h300,  0);
        // misaligned redirect while WAIT: drain, then HALT
        add(0, 0,        1, 0, 0,  0,  1, B+'h304,  0, A5, B+'h300,  0);
        add(1, B+'h3,    0, 0, 0,  0,  0, B+'h304,  0, A5, B+'h300,  0);
        add(0, 0,        0, 0, 0,  0,  0, B+'h304,  0, A5, B+'h300,  1);
        add(0, 0,        0, 1, DEAD, 0, 0, B+'h304, 0, A5, B+'h300,  0);
        add(1, B+'h400,  0, 0, 0,  0,  0, B+'h304,  0, A5, B+'h300,  0);
        add(0, 0,        0, 0, 0,  0,  1, B+'h400,  0, A5, B+'h300,  0);
        add(0, 0,        1, 0, 0,  0,  1, B+'h400,  0, A5, B+'h300,  0);
        add(0, 0,        0, 0, 0,  0,  0, B+'h400,  0, A5, B+'h300,  0);

        @(negedge clk);
        chk("reset", 1'b0, B, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i + 1), vq[i].qv, vq[i].qa,
                vq[i].iv, vq[i].ii, vq[i].ip, vq[i].mis);
            redir_valid = vq[i].ri;
            redir_pc    = vq[i].rp;
            req_ready   = vq[i].rdy;
            rsp_valid   = vq[i].rv;
            rsp_data    = vq[i].rd;
            inst_ready  = vq[i].ir;
        end

        // reset while WAIT; the late response must be ignored
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid", 1'b0, B, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = DEAD;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rst_req", 1'b1, B, 1'b0, '0, '0, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("rst_wait", 1'b0, B, 1'b0, '0, '0, 1'b0);
        rsp_valid = 1'b1;
        rsp_data  = A6;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rst_hold", 1'b0, B+4, 1'b1, A6, B, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
